// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared state encoding and default sizes
// for the instruction-memory loader (DEPTH words, ADDR_W-bit address).
package program_loader_pkg;

  localparam int PL_DEPTH  = 61;
  localparam int PL_ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } pl_state_t;

endpackage

// File: rtl/program_loader_sum.sv
// loader_sum: 8-bit modular accumulator (clock, reset, clear, add_en,
// data in; sum out). Only built with PROGRAM_LOADER_CHECKSUM_EN.
`ifdef PROGRAM_LOADER_CHECKSUM_EN
module loader_sum (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] data,
  output logic [7:0] sum
);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      sum <= 8'd0;
    end else if (add_en) begin
      sum <= sum + data;
    end
  end

endmodule
`endif

// File: rtl/program_loader.sv
// program_loader: writes a length-prefixed byte stream into instruction
// memory from address 0, holding the core in reset until the load is done.
// Ports: clock, reset (sync, active-high), start, in_valid/in_data/in_ready
// stream, mem_we/mem_addr/mem_wdata write port, core_hold, done, error.
// Macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int DEPTH  = PL_DEPTH,
  parameter int ADDR_W = PL_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  pl_state_t         state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              xfer;
  logic              len_bad;

  assign xfer    = in_valid && in_ready;
  assign len_bad = (in_data == 8'd0) ||
                   (32'(in_data) > 32'(DEPTH));

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       sum_clear;
  logic       sum_add;
  logic       sum_ok;

  // Cleared when a load is accepted; covers length and data bytes.
  assign sum_clear = start &&
                     (state == S_IDLE || state == S_DONE ||
                      state == S_ERR);
  assign sum_add   = xfer && (state == S_LEN || state == S_DATA);
  assign sum_ok    = 8'(sum + in_data) == 8'd0;

  loader_sum u_sum (
    .clock  (clock),
    .reset  (reset),
    .clear  (sum_clear),
    .add_en (sum_add),
    .data   (in_data),
    .sum    (sum)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'd0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
      addr_cnt  <= '0;
      last_addr <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state     <= S_LEN;
            in_ready  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
          end
        end
        S_LEN: begin
          if (xfer) begin
            if (len_bad) begin
              state    <= S_ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state     <= S_DATA;
              addr_cnt  <= '0;
              last_addr <= ADDR_W'(in_data - 8'd1);
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= addr_cnt;
            mem_wdata <= in_data;
            if (addr_cnt == last_addr) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state <= S_CSUM;
`else
              // Release lands in the same cycle as the last write.
              state     <= S_DONE;
              in_ready  <= 1'b0;
              done      <= 1'b1;
              core_hold <= 1'b0;
`endif
            end else begin
              addr_cnt <= addr_cnt + ADDR_W'(1);
            end
          end
        end
        S_CSUM: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (xfer) begin
            in_ready <= 1'b0;
            if (sum_ok) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
`else
          state    <= S_IDLE;
          in_ready <= 1'b0;
`endif
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
